// File: rtl/sprite_sched_pkg.sv
// Shared widths, the buffered register-write entry and the scheduler FSM states.
package sprite_sched_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

endpackage

// File: rtl/sprite_sched_fifo.sv
// Circular buffer of pending sprite register writes; pop_dat shows the head combinationally.
// Pushes into a full FIFO and pops from an empty one are ignored, so nothing is overwritten or dropped.
module sprite_sched_fifo
    import sprite_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  wr_entry_t  push_dat,
    input  logic       pop,
    output wr_entry_t  pop_dat,
    output logic       full,
    output logic       empty,
    output logic [3:0] count
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [3:0]       DEPTH_C = 4'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    wr_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == 4'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/sprite_reg_scheduler.sv
// Round-robin CPU/animation register writes into a FIFO, drained one per cycle in vblank; eng_wr_* one cycle after pop.
// Ready only to the granted requester when not full; SPRITE_SCHED_FORCE_DRAIN_EN adds a force_drain input.
module sprite_reg_scheduler
    import sprite_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef SPRITE_SCHED_FORCE_DRAIN_EN
    input  logic              force_drain,
`endif
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              anim_valid,
    output logic              anim_ready,
    input  logic [ADDR_W-1:0] anim_addr,
    input  logic [DATA_W-1:0] anim_data,
    input  logic              vblank,
    output logic              eng_wr_en,
    output logic [ADDR_W-1:0] eng_wr_addr,
    output logic [DATA_W-1:0] eng_wr_data,
    output logic [3:0]        pending,
    output logic              busy,
    output logic              overrun,
    input  logic              overrun_clr
);

    sched_state_t state;
    sched_state_t state_nxt;
    logic         last_grant_anim;
    logic         grant_cpu;
    logic         grant_anim;
    logic         push;
    logic         pop;
    wr_entry_t    push_entry;
    wr_entry_t    pop_entry;
    logic         fifo_full;
    logic         fifo_empty;
    logic [3:0]   fifo_count;
    logic         vblank_q;
    logic         drain_window;
    logic         edge_block;
    logic         overrun_set;

`ifdef SPRITE_SCHED_FORCE_DRAIN_EN
    assign drain_window = vblank || force_drain;
    assign edge_block   = force_drain;
`else
    assign drain_window = vblank;
    assign edge_block   = 1'b0;
`endif

    // Anim wins only when CPU is idle or CPU was served last; full is pre-pop.
    assign grant_cpu  = cpu_valid && (!anim_valid || last_grant_anim);
    assign grant_anim = anim_valid && !grant_cpu;
    assign cpu_ready  = rst_n && grant_cpu && !fifo_full;
    assign anim_ready = rst_n && grant_anim && !fifo_full;
    assign push       = (cpu_valid && cpu_ready) || (anim_valid && anim_ready);

    always_comb begin
        push_entry = '0;
        if (grant_cpu) begin
            push_entry.addr = cpu_addr;
            push_entry.data = cpu_data;
        end else begin
            push_entry.addr = anim_addr;
            push_entry.data = anim_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_anim <= 1'b1;
        end else if (push) begin
            last_grant_anim <= grant_anim;
        end
    end

    sprite_sched_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_entry),
        .pop      (pop),
        .pop_dat  (pop_entry),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (push) state_nxt = drain_window ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (drain_window) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                pop = !fifo_empty;
                // A simultaneous push keeps the FIFO non-empty.
                if (pop && !push && fifo_count == 4'd1) begin
                    state_nxt = ST_IDLE;
                end else if (!drain_window) begin
                    state_nxt = ST_WAIT;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eng_wr_en   <= 1'b0;
            eng_wr_addr <= '0;
            eng_wr_data <= '0;
        end else begin
            eng_wr_en <= pop;
            if (pop) begin
                eng_wr_addr <= pop_entry.addr;
                eng_wr_data <= pop_entry.data;
            end
        end
    end

    // Writes still queued when the raster re-enters the active area missed their frame.
    assign overrun_set = vblank_q && !vblank && !edge_block && !fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vblank_q <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            vblank_q <= vblank;
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign pending = fifo_count;
    assign busy    = !fifo_empty;

endmodule

// File: tb/tb_sprite_reg_scheduler.sv
// Directed bench for sprite_reg_scheduler at the default FIFO depth of 4.
module tb_sprite_reg_scheduler;
    import sprite_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_valid = 1'b0;
    logic        cpu_ready;
    logic [5:0]  cpu_addr = 6'd0;
    logic [15:0] cpu_data = 16'd0;
    logic        anim_valid = 1'b0;
    logic        anim_ready;
    logic [5:0]  anim_addr = 6'd0;
    logic [15:0] anim_data = 16'd0;
    logic        vblank = 1'b0;
    logic        eng_wr_en;
    logic [5:0]  eng_wr_addr;
    logic [15:0] eng_wr_data;
    logic [3:0]  pending;
    logic        busy;
    logic        overrun;
    logic        overrun_clr = 1'b0;
`ifdef SPRITE_SCHED_FORCE_DRAIN_EN
    logic        force_drain = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sprite_reg_scheduler #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef SPRITE_SCHED_FORCE_DRAIN_EN
        .force_drain (force_drain),
`endif
        .cpu_valid   (cpu_valid),
        .cpu_ready   (cpu_ready),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .anim_valid  (anim_valid),
        .anim_ready  (anim_ready),
        .anim_addr   (anim_addr),
        .anim_data   (anim_data),
        .vblank      (vblank),
        .eng_wr_en   (eng_wr_en),
        .eng_wr_addr (eng_wr_addr),
        .eng_wr_data (eng_wr_data),
        .pending     (pending),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [5:0] addr,
                          input logic [15:0] data);
        check({tag, "_en"},   32'(eng_wr_en),   32'(en));
        check({tag, "_addr"}, 32'(eng_wr_addr), 32'(addr));
        check({tag, "_data"}, 32'(eng_wr_data), 32'(data));
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        // Reset with both requesters valid: readies must stay low
        cpu_valid = 1'b1;
        anim_valid = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_cpu_ready",  32'(cpu_ready),  0);
        check("rst_anim_ready", 32'(anim_ready), 0);
        check("rst_pending",    32'(pending),    0);
        check("rst_busy",       32'(busy),       0);
        check("rst_overrun",    32'(overrun),    0);
        check("rst_state",      32'(dut.state),  32'(ST_IDLE));
        chk_wr("rst_wr", 1'b0, 6'h00, 16'h0000);
        cpu_valid = 1'b0;
        anim_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Two CPU writes held until vblank, then drained in order
        cpu_valid = 1'b1;
        cpu_addr = 6'h06;
        cpu_data = 16'hAAAA;
        settle();
        check("basic_cpu_ready", 32'(cpu_ready), 1);
        tick();
        cpu_addr = 6'h08;
        cpu_data = 16'h5555;
        tick();
        cpu_valid = 1'b0;
        check("basic_pending2", 32'(pending), 2);
        check("basic_state_wait", 32'(dut.state), 32'(ST_WAIT));
        chk_wr("basic_nowr", 1'b0, 6'h00, 16'h0000);
        vblank = 1'b1;
        tick();
        check("basic_state_drain", 32'(dut.state), 32'(ST_DRAIN));
        check("basic_pending_pre", 32'(pending), 2);
        check("basic_en_pre", 32'(eng_wr_en), 0);
        tick();
        chk_wr("basic_wr0", 1'b1, 6'h06, 16'hAAAA);
        check("basic_pending1", 32'(pending), 1);
        tick();
        chk_wr("basic_wr1", 1'b1, 6'h08, 16'h5555);
        check("basic_pending0", 32'(pending), 0);
        tick();
        chk_wr("basic_hold", 1'b0, 6'h08, 16'h5555);
        check("basic_busy", 32'(busy), 0);
        check("basic_state_idle", 32'(dut.state), 32'(ST_IDLE));
        vblank = 1'b0;
        tick();
        check("basic_no_overrun", 32'(overrun), 0);

        // Round-robin fill from reset: CPU, anim, CPU, anim
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        cpu_valid = 1'b1;
        cpu_addr = 6'h01;
        cpu_data = 16'h1111;
        anim_valid = 1'b1;
        anim_addr = 6'h02;
        anim_data = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("rr_cpu_ready",  32'(cpu_ready),  32'((i % 2) == 0));
            check("rr_anim_ready", 32'(anim_ready), 32'((i % 2) == 1));
            check("rr_pending",    32'(pending),    32'(i));
            tick();
        end
        check("rr_full_cpu_ready",  32'(cpu_ready),  0);
        check("rr_full_anim_ready", 32'(anim_ready), 0);
        check("rr_full_pending",    32'(pending),    4);

        // Full FIFO: first drain cycle refuses the push, the next accepts
        anim_valid = 1'b0;
        cpu_addr = 6'h03;
        cpu_data = 16'h3333;
        settle();
        check("full_cpu_ready", 32'(cpu_ready), 0);
        vblank = 1'b1;
        tick();
        check("full_pending4", 32'(pending), 4);
        check("full_cpu_ready_drain", 32'(cpu_ready), 0);
        tick();
        check("full_pending3", 32'(pending), 3);
        chk_wr("full_wr0", 1'b1, 6'h01, 16'h1111);
        check("full_cpu_ready_after", 32'(cpu_ready), 1);
        tick();
        cpu_valid = 1'b0;
        check("full_pending_same", 32'(pending), 3);
        chk_wr("full_wr1", 1'b1, 6'h02, 16'h2222);
        tick();
        chk_wr("full_wr2", 1'b1, 6'h01, 16'h1111);
        tick();
        chk_wr("full_wr3", 1'b1, 6'h02, 16'h2222);
        tick();
        chk_wr("full_wr4", 1'b1, 6'h03, 16'h3333);
        check("full_pending0", 32'(pending), 0);
        tick();
        check("full_en_done", 32'(eng_wr_en), 0);
        vblank = 1'b0;
        tick();

        // Six writes outstanding, vblank for two cycles: two writes then overrun
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        cpu_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_addr = 6'(10 + i);
            cpu_data = 16'(16'h0100 + i);
            tick();
        end
        check("ovr_pending4", 32'(pending), 4);
        cpu_addr = 6'd14;
        cpu_data = 16'h0104;
        anim_valid = 1'b1;
        anim_addr = 6'd20;
        anim_data = 16'h0200;
        settle();
        check("ovr_both_blocked", 32'({cpu_ready, anim_ready}), 0);
        vblank = 1'b1;
        tick();
        tick();
        chk_wr("ovr_wr0", 1'b1, 6'd10, 16'h0100);
        check("ovr_pending3", 32'(pending), 3);
        vblank = 1'b0;
        settle();
        check("ovr_anim_turn", 32'({cpu_ready, anim_ready}), 32'(2'b01));
        tick();
        anim_valid = 1'b0;
        chk_wr("ovr_wr1", 1'b1, 6'd11, 16'h0101);
        check("ovr_pending_pushpop", 32'(pending), 3);
        check("ovr_set", 32'(overrun), 1);
        check("ovr_state_wait", 32'(dut.state), 32'(ST_WAIT));
        tick();
        cpu_valid = 1'b0;
        check("ovr_no_third_wr", 32'(eng_wr_en), 0);
        check("ovr_pending4b", 32'(pending), 4);
        check("ovr_sticky", 32'(overrun), 1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_cleared", 32'(overrun), 0);

        // Reset mid-drain with three entries left
        vblank = 1'b1;
        tick();
        tick();
        chk_wr("mid_wr0", 1'b1, 6'd12, 16'h0102);
        check("mid_pending3", 32'(pending), 3);
        rst_n = 1'b0;
        tick();
        check("mid_rst_pending", 32'(pending), 0);
        chk_wr("mid_rst_wr", 1'b0, 6'h00, 16'h0000);
        rst_n = 1'b1;
        tick();
        check("mid_rel_en", 32'(eng_wr_en), 0);
        check("mid_rel_pending", 32'(pending), 0);
        check("mid_rel_busy", 32'(busy), 0);
        check("mid_rel_state", 32'(dut.state), 32'(ST_IDLE));
        vblank = 1'b0;
        tick();
        check("mid_rel_overrun", 32'(overrun), 0);

`ifdef SPRITE_SCHED_FORCE_DRAIN_EN
        // force_drain opens a drain window outside vblank
        cpu_valid = 1'b1;
        cpu_addr = 6'h05;
        cpu_data = 16'hBEEF;
        tick();
        cpu_valid = 1'b0;
        force_drain = 1'b1;
        tick();
        check("fd_en_pre", 32'(eng_wr_en), 0);
        tick();
        chk_wr("fd_wr", 1'b1, 6'h05, 16'hBEEF);
        check("fd_pending0", 32'(pending), 0);
        tick();
        check("fd_single", 32'(eng_wr_en), 0);
        force_drain = 1'b0;
        tick();
        check("fd_overrun", 32'(overrun), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sprite_reg_scheduler.md
SPRITE_REG_SCHEDULER -- requirements
Module: sprite_reg_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered register writes (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  clock.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports cpu_valid  input  1, cpu_ready  output  1, cpu_addr  input  6, cpu_data  input  16: CPU write request channel.
REQ-005 SHALL have ports anim_valid  input  1, anim_ready  output  1, anim_addr  input  6, anim_data  input  16: animation-sequencer write request channel.
REQ-006 SHALL have port vblank  input  1  high while the sprite engine raster is outside the active area.
REQ-007 SHALL have ports eng_wr_en  output  1, eng_wr_addr  output  6, eng_wr_data  output  16: 16-bit register write port into the sprite engine.
REQ-008 SHALL have ports pending  output  4  FIFO occupancy; busy  output  1  FIFO non-empty; overrun  output  1  sticky missed-frame flag; overrun_clr  input  1  clears overrun.

Function
REQ-009 SHALL arbitrate the two requesters round-robin onto one FIFO push per cycle; a request is accepted when valid && ready.
REQ-010 SHALL drive ready only to the granted requester, and only when FIFO not full (full evaluated before any same-cycle pop).
REQ-011 SHALL grant the requester not granted last when both are valid; last_grant resets to anim, so CPU wins the first contention.
REQ-012 SHALL grant a lone valid requester regardless of last_grant; last_grant updates only on an accepted push.
REQ-013 SHALL use FSM states IDLE (empty), WAIT (non-empty, vblank low), DRAIN (non-empty, vblank high).
REQ-014 SHALL transition IDLE->WAIT on push with vblank low, IDLE->DRAIN on push with vblank high, WAIT->DRAIN on vblank high, DRAIN->WAIT on vblank low with entries remaining, DRAIN->IDLE when the last entry pops.
REQ-015 SHALL pop one entry per cycle in DRAIN; eng_wr_en/addr/data are registered, asserted the cycle after the pop, FIFO order preserved.
REQ-016 SHALL keep eng_wr_en low and addr/data at their previous values when not writing.
REQ-017 SHALL keep pending unchanged on simultaneous push and pop; pending never exceeds FIFO_DEPTH.
REQ-018 SHALL set overrun on a vblank falling edge with FIFO non-empty; overrun_clr clears it; set wins over simultaneous clear.
REQ-019 SHALL never accept a push into a full FIFO (no overwrite, no drop).

Reset
REQ-020 SHALL on rst_n low clear FIFO, pending=0, busy=0, overrun=0, eng_wr_en=0, eng_wr_addr=0, eng_wr_data=0, cpu_ready=0, anim_ready=0, state IDLE, last_grant=anim.
REQ-021 SHALL discard in-flight entries on reset mid-drain; no eng_wr_en in the cycle after reset release.
REQ-022 SHALL sample vblank edge-detect history as 0 at reset, so vblank high at release is not an edge.

Configuration
REQ-023 SHALL, with SPRITE_SCHED_FORCE_DRAIN_EN defined, add input force_drain (1 bit); FSM treats vblank||force_drain as the drain window and overrun ignores edges while force_drain is high.
REQ-024 SHALL, without SPRITE_SCHED_FORCE_DRAIN_EN, omit force_drain; draining occurs only during vblank.

Structure
REQ-025 SHALL place ADDR_W=6, DATA_W=16, the write-entry typedef (addr+data) and the FSM state enum in package sprite_sched_pkg.
REQ-026 SHALL implement storage in one sub-module sprite_sched_fifo (push/pop/full/empty/count, FIFO_DEPTH parameter).

Verification
REQ-027 SHALL cover: vblank=0, CPU pushes (0x06,0xAAAA),(0x08,0x5555) -> no eng_wr_en; vblank=1 -> writes appear in order on two consecutive cycles, each one cycle after pop, pending 2->0.
REQ-028 SHALL cover: both valid every cycle, vblank=0, depth 4 -> grants CPU,anim,CPU,anim; then both ready=0, pending=4.
REQ-029 SHALL cover: FIFO full, vblank rises, CPU valid -> first cycle no accept (pending 4->3), next cycle accept (pending 3).
REQ-030 SHALL cover: 6 entries queued, vblank high only 2 cycles -> 2 writes, overrun=1 after vblank falls, overrun_clr -> 0.
REQ-031 SHALL cover: reset asserted mid-drain with 3 pending -> pending=0, eng_wr_en=0, state IDLE after release.
REQ-032 SHALL cover (macro defined): vblank=0, force_drain=1, 1 pending -> single write, overrun stays 0.
